nibble_serial_adder: RTL

Sequential front-end that performs WIDTH-bit addition by streaming operands through a single `cla_4bit` instance, one nibble per clock, least significant nibble first. It accepts operands over a valid/ready handshake and registers the carry between nibbles. It presents the full sum, carry-out and signed-overflow flag over a second valid/ready handshake. It sits directly upstream of `cla_4bit`, which it owns and drives, and lets the existing 4-bit adder serve arbitrary word widths at one nibble per cycle.

---
 rtl/nibble_serial_adder_pkg.sv | 13 +
 rtl/nibble_serial_adder_cla.sv | 30 +++
 rtl/nibble_serial_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared encodings for the nibble-serial adder: FSM states and nibble width.
// No logic; imported by the top.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead adder (existing block, reused as-is).
// Purely combinational; no handshake.
module cla_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign Sum  = w_p ^ w_c[3:0];
    assign Cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder streaming one nibble per clock through a single cla_4bit, LSB nibble first.
// Result valid WIDTH/4 cycles after accept; holds result in DONE until out_ready, no overlap.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_out_valid;

    logic [NIBBLE_W-1:0] w_nib_a;
    logic [NIBBLE_W-1:0] w_nib_b;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;
    logic                w_last;

    assign w_nib_a = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_nib_b = r_b[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_last  = (r_idx == LAST_IDX);

    cla_4bit u_cla (
        .A    (w_nib_a),
        .B    (w_nib_b),
        .Cin  (r_carry),
        .Sum  (w_nib_sum),
        .Cout (w_nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_nib_sum;
                    r_carry <= w_nib_cout;
                    r_idx   <= r_idx + 1'b1;
                    // Top nibble: its sum MSB is the word MSB used for signed overflow.
                    if (w_last) begin
                        r_cout      <= w_nib_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_nib_sum[NIBBLE_W-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule
